// File: rtl/fpa_pkg.sv
// Shared constants for the feature-point animator: initial point table,
// per-point speeds, direction encoding and FSM state codes.
package fpa_pkg;

    // Initial coordinates and per-axis speeds for up to eight points.
    localparam int PT_INIT_X [8] = '{100, 300, 500, 100, 320, 320, 320, 320};
    localparam int PT_INIT_Y [8] = '{100, 200, 400, 460, 240, 240, 240, 240};
    localparam int PT_VX     [8] = '{1, 2, 1, 3, 1, 1, 1, 1};
    localparam int PT_VY     [8] = '{1, 1, 3, 2, 1, 1, 1, 1};

    // Direction bit encoding: 0 moves toward larger coordinates.
    localparam logic DIR_POS = 1'b0;
    localparam logic DIR_NEG = 1'b1;

    // Update FSM state codes.
    typedef logic [1:0] fpa_state_t;
    localparam fpa_state_t ST_IDLE   = 2'd0;
    localparam fpa_state_t ST_STEP   = 2'd1;
    localparam fpa_state_t ST_COMMIT = 2'd2;

endpackage

// File: rtl/fpa_axis_step.sv
// One-axis bounce step: moves p by v in direction dir, clamping to 0..pmax
// and reversing direction on contact with either edge.
module fpa_axis_step
    import fpa_pkg::*;
#(
    parameter int COORD_W = 10,
    parameter int VEL_W   = 4
) (
    input  logic [COORD_W-1:0] p,
    input  logic [VEL_W-1:0]   v,
    input  logic               dir,
    input  logic [COORD_W-1:0] pmax,
    output logic [COORD_W-1:0] p_next,
    output logic               dir_next
);

    // One extra bit so p + v can never wrap before the edge compare.
    logic [COORD_W:0] p_ext;
    logic [COORD_W:0] v_ext;
    logic [COORD_W:0] sum;
    logic [COORD_W:0] max_ext;
    logic [COORD_W:0] diff;

    assign p_ext   = {1'b0, p};
    assign v_ext   = (COORD_W+1)'(v);
    assign max_ext = {1'b0, pmax};
    assign sum     = p_ext + v_ext;
    assign diff    = p_ext - v_ext;

    // Edge-bounce decision for the current direction.
    always_comb begin
        p_next   = p;
        dir_next = dir;
        if (dir == DIR_POS) begin
            if (sum >= max_ext) begin
                p_next   = pmax;
                dir_next = DIR_NEG;
            end else begin
                p_next = sum[COORD_W-1:0];
            end
        end else begin
            if (p_ext <= v_ext) begin
                p_next   = '0;
                dir_next = DIR_POS;
            end else begin
                p_next = diff[COORD_W-1:0];
            end
        end
    end

endmodule

// File: rtl/feature_point_animator.sv
// Per-frame animation state for the Worley noise stage. On each frame tick
// the points are stepped one per cycle into shadow registers, then all of
// them are committed together so consumers never see a partial set.
module feature_point_animator
    import fpa_pkg::*;
#(
    parameter int NUM_PTS = 4,
    parameter int COORD_W = 10,
    parameter int H_MAX   = 639,
    parameter int V_MAX   = 479,
    parameter int VEL_W   = 4,
    parameter int FRAME_W = 20
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [9:0]                 vpos,
    input  logic                       run,
    output logic [NUM_PTS*COORD_W-1:0] pts_x,
    output logic [NUM_PTS*COORD_W-1:0] pts_y,
    output logic [FRAME_W-1:0]         frame_cnt,
    output logic                       busy,
    output logic                       upd_valid,
    output logic                       overrun
);

    localparam int IDX_W = (NUM_PTS > 1) ? $clog2(NUM_PTS) : 1;
    localparam logic [COORD_W-1:0] X_MAX = COORD_W'(H_MAX);
    localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(V_MAX);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_PTS - 1);

    fpa_state_t state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [9:0]         vpos_prev_q, vpos_prev_d;
    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
    logic               overrun_q, overrun_d;

    logic [COORD_W-1:0] pts_x_q [NUM_PTS];
    logic [COORD_W-1:0] pts_x_d [NUM_PTS];
    logic [COORD_W-1:0] pts_y_q [NUM_PTS];
    logic [COORD_W-1:0] pts_y_d [NUM_PTS];
    logic [COORD_W-1:0] sh_x_q  [NUM_PTS];
    logic [COORD_W-1:0] sh_x_d  [NUM_PTS];
    logic [COORD_W-1:0] sh_y_q  [NUM_PTS];
    logic [COORD_W-1:0] sh_y_d  [NUM_PTS];
    logic               dir_x_q [NUM_PTS];
    logic               dir_x_d [NUM_PTS];
    logic               dir_y_q [NUM_PTS];
    logic               dir_y_d [NUM_PTS];

    logic [COORD_W-1:0] init_x [NUM_PTS];
    logic [COORD_W-1:0] init_y [NUM_PTS];
    logic [VEL_W-1:0]   vx_tab [NUM_PTS];
    logic [VEL_W-1:0]   vy_tab [NUM_PTS];

    logic               tick;
    logic [COORD_W-1:0] nx, ny;
    logic               ndx, ndy;

    // Narrow the package tables to this instance's widths and point count.
    always_comb begin
        for (int i = 0; i < NUM_PTS; i++) begin
            init_x[i] = COORD_W'(PT_INIT_X[i]);
            init_y[i] = COORD_W'(PT_INIT_Y[i]);
            vx_tab[i] = VEL_W'(PT_VX[i]);
            vy_tab[i] = VEL_W'(PT_VY[i]);
        end
    end

    // A frame starts when vpos returns to line 0 from any other line.
    assign tick = (vpos == 10'd0) && (vpos_prev_q != 10'd0);

    // One step unit per axis, time-shared across points by idx.
    fpa_axis_step #(.COORD_W(COORD_W), .VEL_W(VEL_W)) u_step_x (
        .p        (sh_x_q[idx_q]),
        .v        (vx_tab[idx_q]),
        .dir      (dir_x_q[idx_q]),
        .pmax     (X_MAX),
        .p_next   (nx),
        .dir_next (ndx)
    );

    fpa_axis_step #(.COORD_W(COORD_W), .VEL_W(VEL_W)) u_step_y (
        .p        (sh_y_q[idx_q]),
        .v        (vy_tab[idx_q]),
        .dir      (dir_y_q[idx_q]),
        .pmax     (Y_MAX),
        .p_next   (ny),
        .dir_next (ndy)
    );

    // Update FSM: start on tick, step each point, then commit the set.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        vpos_prev_d = vpos;
        frame_cnt_d = frame_cnt_q;
        overrun_d   = overrun_q;
        pts_x_d     = pts_x_q;
        pts_y_d     = pts_y_q;
        sh_x_d      = sh_x_q;
        sh_y_d      = sh_y_q;
        dir_x_d     = dir_x_q;
        dir_y_d     = dir_y_q;

        // A tick during an update is dropped but remembered.
        if (tick && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    frame_cnt_d = frame_cnt_q + 1'b1;
                    idx_d       = '0;
                    state_d     = ST_STEP;
                end
            end
            ST_STEP: begin
                // With run low the shadow simply keeps its contents.
                if (run) begin
                    sh_x_d[idx_q]  = nx;
                    sh_y_d[idx_q]  = ny;
                    dir_x_d[idx_q] = ndx;
                    dir_y_d[idx_q] = ndy;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = ST_COMMIT;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_COMMIT: begin
                pts_x_d = sh_x_q;
                pts_y_d = sh_y_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset back to the initial table.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            vpos_prev_q <= '0;
            frame_cnt_q <= '0;
            overrun_q   <= 1'b0;
            for (int i = 0; i < NUM_PTS; i++) begin
                pts_x_q[i] <= init_x[i];
                pts_y_q[i] <= init_y[i];
                sh_x_q[i]  <= init_x[i];
                sh_y_q[i]  <= init_y[i];
                dir_x_q[i] <= DIR_POS;
                dir_y_q[i] <= DIR_POS;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            vpos_prev_q <= vpos_prev_d;
            frame_cnt_q <= frame_cnt_d;
            overrun_q   <= overrun_d;
            pts_x_q     <= pts_x_d;
            pts_y_q     <= pts_y_d;
            sh_x_q      <= sh_x_d;
            sh_y_q      <= sh_y_d;
            dir_x_q     <= dir_x_d;
            dir_y_q     <= dir_y_d;
        end
    end

    // Pack committed coordinates onto the output buses.
    always_comb begin
        for (int i = 0; i < NUM_PTS; i++) begin
            pts_x[i*COORD_W +: COORD_W] = pts_x_q[i];
            pts_y[i*COORD_W +: COORD_W] = pts_y_q[i];
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != ST_IDLE);
    assign upd_valid = (state_q == ST_COMMIT);

endmodule

// File: tb/tb_feature_point_animator.sv
// Directed bench for feature_point_animator: reset values, frame latency,
// motion and edge bounces, run hold, overrun and reset mid-update.
module tb_feature_point_animator;

    localparam int N  = 4;
    localparam int CW = 10;
    localparam int FW = 20;

    logic            clk = 1'b0;
    logic            reset;
    logic [9:0]      vpos;
    logic            run;
    logic [N*CW-1:0] pts_x;
    logic [N*CW-1:0] pts_y;
    logic [FW-1:0]   frame_cnt;
    logic            busy;
    logic            upd_valid;
    logic            overrun;

    int checks = 0;
    int fails  = 0;
    int upd_cnt = 0;
    int upd_snap;

    feature_point_animator #(
        .NUM_PTS(N), .COORD_W(CW), .H_MAX(639), .V_MAX(479),
        .VEL_W(4), .FRAME_W(FW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .vpos      (vpos),
        .run       (run),
        .pts_x     (pts_x),
        .pts_y     (pts_y),
        .frame_cnt (frame_cnt),
        .busy      (busy),
        .upd_valid (upd_valid),
        .overrun   (overrun)
    );

    // clock
    always #5 clk = ~clk;

    // commit pulses seen mid-cycle
    always @(negedge clk) begin
        if (upd_valid === 1'b1) upd_cnt++;
    end

    function automatic logic [CW-1:0] px(input int i);
        return pts_x[i*CW +: CW];
    endfunction

    function automatic logic [CW-1:0] py(input int i);
        return pts_y[i*CW +: CW];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // advance one clock; sampling/driving happens 1ns after the edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // one full frame: vpos leaves 0 then returns, then wait past commit
    task automatic frame();
        vpos = 10'd524;
        cyc();
        vpos = 10'd0;
        repeat (6) cyc();
    endtask

    task automatic frames(input int n);
        for (int k = 0; k < n; k++) frame();
    endtask

    initial begin
        reset = 1'b1;
        vpos  = 10'd0;
        run   = 1'b1;
        repeat (3) cyc();

        // reset values
        chk("rst_p0x", 32'(px(0)), 100);
        chk("rst_p0y", 32'(py(0)), 100);
        chk("rst_p3x", 32'(px(3)), 100);
        chk("rst_p3y", 32'(py(3)), 460);
        chk("rst_fc", 32'(frame_cnt), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_upd", 32'(upd_valid), 0);
        chk("rst_ovr", 32'(overrun), 0);
        reset = 1'b0;
        repeat (3) cyc();
        chk("idle_no_tick_fc", 32'(frame_cnt), 0);
        chk("idle_no_tick_busy", 32'(busy), 0);

        // frame 1 with cycle-exact latency
        vpos = 10'd524;
        cyc();
        vpos = 10'd0;
        chk("t0_busy", 32'(busy), 0);
        cyc();
        chk("t1_busy", 32'(busy), 1);
        chk("t1_upd", 32'(upd_valid), 0);
        chk("t1_fc", 32'(frame_cnt), 1);
        repeat (3) cyc();
        chk("t4_busy", 32'(busy), 1);
        chk("t4_upd", 32'(upd_valid), 0);
        cyc();
        chk("t5_busy", 32'(busy), 1);
        chk("t5_upd", 32'(upd_valid), 1);
        chk("t5_p0x_old", 32'(px(0)), 100);
        cyc();
        chk("t6_busy", 32'(busy), 0);
        chk("t6_upd", 32'(upd_valid), 0);
        chk("f1_p0x", 32'(px(0)), 101);
        chk("f1_p0y", 32'(py(0)), 101);
        chk("f1_p1x", 32'(px(1)), 302);
        chk("f1_p1y", 32'(py(1)), 201);
        chk("f1_p2x", 32'(px(2)), 501);
        chk("f1_p2y", 32'(py(2)), 403);
        chk("f1_p3x", 32'(px(3)), 103);
        chk("f1_p3y", 32'(py(3)), 462);
        chk("f1_upd_cnt", 32'(upd_cnt), 1);

        // frames 2..3
        frames(2);
        chk("f3_fc", 32'(frame_cnt), 3);
        chk("f3_p0x", 32'(px(0)), 103);
        chk("f3_p1x", 32'(px(1)), 306);
        chk("f3_p2y", 32'(py(2)), 409);
        chk("f3_p3y", 32'(py(3)), 466);

        // run held low for five frames
        upd_snap = upd_cnt;
        run = 1'b0;
        frames(5);
        chk("hold_fc", 32'(frame_cnt), 8);
        chk("hold_upd", 32'(upd_cnt - upd_snap), 5);
        chk("hold_p0x", 32'(px(0)), 103);
        chk("hold_p1x", 32'(px(1)), 306);
        chk("hold_p2y", 32'(py(2)), 409);
        chk("hold_p3y", 32'(py(3)), 466);
        run = 1'b1;

        // bottom bounce of point 3 (motion frames 9, 10, 11)
        frames(6);
        chk("m9_p3y", 32'(py(3)), 478);
        frame();
        chk("m10_p3y_clamp", 32'(py(3)), 479);
        frame();
        chk("m11_p3y", 32'(py(3)), 477);

        // right bounce of point 2 (motion frames 139, 140, 141)
        frames(128);
        chk("m139_p2x_clamp", 32'(px(2)), 639);
        frame();
        chk("m140_p2x", 32'(px(2)), 638);
        frame();
        chk("m141_p2x", 32'(px(2)), 637);
        chk("m141_p2y", 32'(py(2)), 137);
        chk("m141_p0x", 32'(px(0)), 241);
        chk("m141_p1x", 32'(px(1)), 582);
        chk("m141_p1y", 32'(py(1)), 341);
        chk("m141_p3x", 32'(px(3)), 523);
        chk("m141_p3y", 32'(py(3)), 217);
        chk("m141_fc", 32'(frame_cnt), 146);
        chk("m141_ovr", 32'(overrun), 0);

        // overrun: second tick two cycles after the first
        vpos = 10'd524;
        cyc();
        vpos = 10'd0;
        cyc();
        vpos = 10'd5;
        cyc();
        vpos = 10'd0;
        cyc();
        chk("ovr_set", 32'(overrun), 1);
        chk("ovr_fc", 32'(frame_cnt), 147);
        chk("ovr_busy", 32'(busy), 1);

        // reset in the middle of the update
        upd_snap = upd_cnt;
        reset = 1'b1;
        cyc();
        chk("mid_rst_ovr", 32'(overrun), 0);
        chk("mid_rst_fc", 32'(frame_cnt), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_upd", 32'(upd_valid), 0);
        chk("mid_rst_p0x", 32'(px(0)), 100);
        chk("mid_rst_p2x", 32'(px(2)), 500);
        chk("mid_rst_p3y", 32'(py(3)), 460);
        reset = 1'b0;
        repeat (8) cyc();
        chk("post_rst_busy", 32'(busy), 0);
        chk("post_rst_upd_cnt", 32'(upd_cnt - upd_snap), 0);
        chk("post_rst_p1x", 32'(px(1)), 300);

        // first frame after reset starts again from the initial table
        frame();
        chk("post_f1_fc", 32'(frame_cnt), 1);
        chk("post_f1_p3x", 32'(px(3)), 103);
        chk("post_f1_p2y", 32'(py(2)), 403);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

    // global time bound
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/feature_point_animator.md
Name: feature_point_animator

Overview:
Upstream stage of the Worley noise generator. Owns the per-frame animation state: the frame counter and the NUM_PTS feature-point coordinates. On each frame start it updates the points one per cycle, with edge-bouncing motion, into shadow registers. It then commits all points at once, so the noise stage never sees a partially updated set within a frame.

Parameters:
NUM_PTS, 4, number of feature points (1..8)
COORD_W, 10, coordinate width in bits
H_MAX, 639, largest legal x (active width minus 1)
V_MAX, 479, largest legal y (active height minus 1)
VEL_W, 4, unsigned per-axis speed width
FRAME_W, 20, frame counter width

Ports:
clk  in  1  pixel clock
reset  in  1  synchronous, active-high reset
vpos  in  10  current line from hvsync_generator
run  in  1  1 = points move on frame update; 0 = positions held
pts_x  out  NUM_PTS*COORD_W  committed x coordinates; point i in [i*COORD_W +: COORD_W]
pts_y  out  NUM_PTS*COORD_W  committed y coordinates, same packing as pts_x
frame_cnt  out  FRAME_W  frames since reset, wraps modulo 2^FRAME_W
busy  out  1  high while an update is in progress
upd_valid  out  1  one-cycle pulse in the cycle the new set becomes visible
overrun  out  1  sticky; set when a frame tick arrives while busy

Behaviour:
- Clocking and reset: one clock, clk. reset is synchronous and active-high.
- Reset values:
  - pts_x/pts_y and the shadow registers = package init table.
  - All direction bits = positive.
  - frame_cnt = 0; busy = 0; upd_valid = 0; overrun = 0.
  - FSM = IDLE; vpos_prev = 0.
  - Consequence: the first tick occurs at the first genuine 0→nonzero→0 return of vpos after reset.
- Frame tick: tick = (vpos == 0) && (vpos_prev != 0). vpos_prev is registered every cycle.
- FSM states: IDLE, STEP, COMMIT.
  - IDLE + tick: frame_cnt += 1; idx = 0; → STEP; busy = 1 from the next cycle.
  - STEP: compute point idx into the shadow registers. If idx == NUM_PTS-1 → COMMIT, else idx += 1.
  - COMMIT: shadow → pts_x/pts_y in one cycle; upd_valid = 1 in this cycle only; → IDLE; busy drops.
- Latency: tick cycle T; busy high from T+1 through T+NUM_PTS+1; pts_x/pts_y change at T+NUM_PTS+2 (register update at the COMMIT edge); upd_valid high at T+NUM_PTS+1.
- Per-axis motion (independently for x and y; v = speed, M = H_MAX or V_MAX):
  - dir +: if p + v >= M then p' = M and dir flips to −, else p' = p + v.
  - dir −: if p <= v then p' = 0 and dir flips to +, else p' = p − v.
  - Arithmetic is COORD_W+1 bits unsigned; there is no wrap-around. Result is always in 0..M.
  - v = 0 → point is static.
- run = 0: STEP writes the shadow unchanged (positions and dirs held). frame_cnt still increments and upd_valid still pulses.
- Tick while busy: ignored; no restart, no extra frame_cnt increment; overrun set until reset.
- Reset mid-update: abandons the update; all state returns to reset values; outputs never show a mixed set.
- frame_cnt wraps from 2^FRAME_W−1 to 0 without side effects.

Decomposition:
- Package fpa_pkg holds:
  - localparam tables PT_INIT_X, PT_INIT_Y, PT_VX, PT_VY, indexed 0..7.
  - Init values: p0 (100,100) v(1,1); p1 (300,200) v(2,1); p2 (500,400) v(1,3); p3 (100,460) v(3,2). Entries 4..7 = (320,240) v(1,1).
  - FSM state enum.
- One sub-module, fpa_axis_step: purely combinational single-axis bounce step.
  - Inputs: p, v, dir, max. Outputs: p', dir'.
  - Instantiated twice (x, y) and shared across points via idx muxing.

Test Plan:
- Reset: hold reset 3 cycles → pts point0 = (100,100), point3 = (100,460); frame_cnt = 0; busy/upd_valid/overrun = 0.
- Single tick: vpos 524→0 at cycle T → busy T+1..T+5, upd_valid at T+5 only, frame_cnt = 1; at T+6 p0 = (101,101), p1 = (302,201), p2 = (501,403), p3 = (103,462).
- Bottom bounce: 10 frames → p3 y sequence 462,464,…,478, then 479 (clamped, dir −); frame 11 → 477.
- Right bounce: 139 frames → p2 x = 639; frame 140 → 638; frame 141 → 637.
- run = 0 for 5 frames after frame 3 → positions equal frame-3 values; frame_cnt = 8; five upd_valid pulses.
- Overrun/reset: second tick at T+2 → ignored, frame_cnt +1 only, overrun = 1; then reset at T+3 → reset values everywhere, overrun = 0.
